mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA_W, 16, datapath width for address, store data, read data and writeback data.
REQ-002 Parameter TIMEOUT, 15, maximum BUSY cycles without mem_ack before an error is declared; legal range 1..255.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 InValid  in  1  EX/MEM register holds a valid instruction.
REQ-007 RtIn  in  DATA_W  store data.
REQ-008 ALUoutIn  in  DATA_W  memory address, or ALU result for non-memory ops.
REQ-009 MemEnableIn  in  1  instruction accesses data memory.
REQ-010 MemWrIn  in  1  access is a store (1) or a load (0).
REQ-011 HaltIn  in  1  instruction is HALT.
REQ-012 Val2RegIn  in  1  writeback selects memory data (1) or ALU result (0).
REQ-013 Stall  out  1  upstream freezes EX/MEM and earlier stages.
REQ-014 MemReq, MemWr  out  1 each  memory request and direction.
REQ-015 MemAddr, MemWdata  out  DATA_W each  memory address and store data.
REQ-016 MemRdata  in  DATA_W  load data, valid with MemAck.
REQ-017 MemAck  in  1  one-cycle completion pulse from memory.
REQ-018 WbValidOut  out  1  one-cycle pulse per retired instruction.
REQ-019 WbDataOut  out  DATA_W  writeback value.
REQ-020 HaltOut, ErrOut  out  1 each  halt retired; sticky memory-timeout error.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and HALTED.
- IDLE, InValid, HaltIn=1: retire next cycle with HaltOut=1 and no memory access (halt has priority over MemEnableIn); go to HALTED.
- IDLE, InValid, MemEnableIn=1, HaltIn=0: capture address, store data, MemWrIn and Val2RegIn; go to BUSY; Stall=1 combinationally in the accept cycle.
- IDLE, InValid, MemEnableIn=0: next cycle WbValidOut=1, WbDataOut=ALUoutIn; latency 1; Stall=0.
REQ-022 In BUSY, MemReq SHALL be registered high with MemAddr, MemWdata and MemWr held stable from the captured values until the MemAck cycle inclusive, then deasserted.
REQ-023 On MemAck in BUSY, the next cycle SHALL give WbValidOut=1; WbDataOut=MemRdata (sampled at ack) if load and Val2Reg=1, else the captured ALUout; state returns to IDLE.
REQ-024 Stall SHALL equal 1 in every BUSY cycle, including the ack cycle, and 0 in the cycle after return to IDLE.
REQ-025 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
- If the counter reaches TIMEOUT: MemReq=0, ErrOut=1 (sticky), no WbValidOut, go to HALTED.
REQ-026 MemAck and timeout in the same cycle: the ack SHALL win and no error is raised.
REQ-027 MemAck while not BUSY SHALL be ignored.
REQ-028 HALTED SHALL hold Stall=1 and MemReq=0 and ignore all inputs until reset; HaltOut SHALL remain 1 after a halt retires.
REQ-029 WbValidOut SHALL never exceed one pulse per accepted instruction; WbDataOut SHALL hold its last value when WbValidOut=0.

Reset
REQ-030 Reset assertion SHALL asynchronously force IDLE, a counter of 0, and all outputs to 0, including MemReq mid-BUSY; an in-flight access is dropped without writeback.
REQ-031 The first acceptance after reset SHALL occur no earlier than the first rising clk edge after rst deasserts.

Structure
REQ-032 A shared package mem_stage_pkg SHALL hold the state encoding, the DATA_W default and the TIMEOUT default.
REQ-033 The wait counter SHALL be a separate sub-module mem_timeout_ctr (clear, enable, count, expired).

Verification
REQ-034 ALU op: ALUoutIn=0x1234, MemEnableIn=0 -> next cycle WbValidOut=1, WbDataOut=0x1234, Stall never 1.
REQ-035 Load: addr 0x0040, Val2Reg=1, MemAck 3 cycles after MemReq with MemRdata=0xBEEF -> MemReq high 4 cycles, then WbDataOut=0xBEEF, WbValidOut=1.
REQ-036 Store: addr 0x0010, RtIn=0xA5A5, ack after 1 cycle -> MemWr=1, MemWdata=0xA5A5 stable; WbDataOut=0x0010.
REQ-037 Timeout: TIMEOUT=4, no ack -> MemReq drops after the 4th BUSY cycle, ErrOut=1, Stall stays 1, and no WbValidOut.
REQ-038 Ack on exactly the TIMEOUT cycle -> normal retire with ErrOut=0; HALT with MemEnableIn=1 -> HaltOut=1, MemReq never asserted.
REQ-039 Reset pulled low mid-BUSY -> MemReq=0 and Stall=0 immediately without waiting for clk; after release, an ALU op retires normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM stage.
//   - FSM state encoding (IDLE / BUSY / HALTED)
//   - default datapath width and memory-timeout limit
package mem_stage_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: 8-bit wait counter for an outstanding memory access.
//   clk, rst    clock, async active-low reset
//   clear       zero the count (takes priority over enable)
//   enable      count one more cycle without an ack
//   count       current number of unacknowledged BUSY cycles
//   expired     this enabled cycle is the LIMIT-th one without an ack
module mem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       expired
);

  // Flag in the cycle whose increment would reach LIMIT, so the stage can
  // leave BUSY on that same edge.
  assign expired = enable && (count == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= 8'd0;
    else if (clear)  count <= 8'd0;
    else if (enable) count <= count + 8'd1;
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a single outstanding
// request/ack memory access, writeback select, HALT retire and timeout.
//   clk, rst                 clock, async active-low reset
//   InValid..Val2RegIn       EX/MEM register contents
//   Stall                    freeze upstream stages
//   MemReq/MemWr/MemAddr/
//   MemWdata                 registered memory request, held until ack
//   MemRdata, MemAck         load data and one-cycle completion pulse
//   WbValidOut, WbDataOut    one-cycle retire pulse and writeback value
//   HaltOut, ErrOut          halt retired; sticky memory timeout
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  input  logic [DATA_W-1:0] RtIn,
  input  logic [DATA_W-1:0] ALUoutIn,
  input  logic              MemEnableIn,
  input  logic              MemWrIn,
  input  logic              HaltIn,
  input  logic              Val2RegIn,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWr,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck,
  output logic              WbValidOut,
  output logic [DATA_W-1:0] WbDataOut,
  output logic              HaltOut,
  output logic              ErrOut
);

  logic [1:0] state;
  logic       val2RegQ;
  logic [7:0] waitCount;
  logic       ctrExpired;

  logic idle, busy, halted;
  logic acceptHalt, acceptMem, acceptAlu, timeoutHit;

  assign idle   = (state == ST_IDLE);
  assign busy   = (state == ST_BUSY);
  assign halted = (state == ST_HALTED);

  // HALT wins over a memory access in the same instruction.
  assign acceptHalt = idle && InValid && HaltIn;
  assign acceptMem  = idle && InValid && !HaltIn && MemEnableIn;
  assign acceptAlu  = idle && InValid && !HaltIn && !MemEnableIn;

  // Gated by rst so Stall reads 0 while reset is held, whatever the inputs.
  assign Stall = rst && (busy || halted || acceptMem);

  mem_timeout_ctr #(.LIMIT(TIMEOUT)) uCtr (
    .clk     (clk),
    .rst     (rst),
    .clear   (acceptMem),
    .enable  (busy && !MemAck),
    .count   (waitCount),
    .expired (ctrExpired)
  );

  // Second term only guards against an overshot count; ack is checked first.
  assign timeoutHit = ctrExpired || (busy && !MemAck && (waitCount >= 8'(TIMEOUT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      val2RegQ   <= 1'b0;
      MemReq     <= 1'b0;
      MemWr      <= 1'b0;
      MemAddr    <= '0;
      MemWdata   <= '0;
      WbValidOut <= 1'b0;
      WbDataOut  <= '0;
      HaltOut    <= 1'b0;
      ErrOut     <= 1'b0;
    end else begin
      WbValidOut <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acceptHalt) begin
            HaltOut <= 1'b1;
            state   <= ST_HALTED;
          end else if (acceptMem) begin
            MemReq   <= 1'b1;
            MemWr    <= MemWrIn;
            MemAddr  <= ALUoutIn;
            MemWdata <= RtIn;
            val2RegQ <= Val2RegIn;
            state    <= ST_BUSY;
          end else if (acceptAlu) begin
            WbValidOut <= 1'b1;
            WbDataOut  <= ALUoutIn;
          end
        end
        ST_BUSY: begin
          if (MemAck) begin
            MemReq     <= 1'b0;
            WbValidOut <= 1'b1;
            // MemAddr still holds the captured ALU result.
            WbDataOut  <= (!MemWr && val2RegQ) ? MemRdata : MemAddr;
            state      <= ST_IDLE;
          end else if (timeoutHit) begin
            MemReq <= 1'b0;
            ErrOut <= 1'b1;
            state  <= ST_HALTED;
          end
        end
        ST_HALTED: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
